ctrl_sequencer: RTL

- Microcoded control unit for the 8-bit bus CPU.
- A 3-bit step counter and halt FSM, together with the current opcode and ALU flags, decode one 16-bit control word per clock.
- The control word drives every bus-attached block: register A/B in/out enables, memory, IR, PC, ALU and output register.
- Sits between the instruction register's upper nibble and the register/bus fabric.

---
 rtl/ctrl_sequencer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ctrl_sequencer.sv
// Microcoded control sequencer: step counter + halt FSM decode one 16-bit control word per cycle.
// ctrl_word is combinational from current state; run=0 pauses the step and forces the idle word.
module ctrl_sequencer #(
    parameter int STEP_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [3:0]        opcode,
    input  logic              flag_c,
    input  logic              flag_z,
    output logic [15:0]       ctrl_word,
    output logic [STEP_W-1:0] step,
    output logic              halted
);

    // Control word bit masks
    localparam logic [15:0] B_HLT = 16'h8000;
    localparam logic [15:0] B_MI  = 16'h4000;
    localparam logic [15:0] B_RI  = 16'h2000;
    localparam logic [15:0] B_RO  = 16'h1000;
    localparam logic [15:0] B_IO  = 16'h0800;
    localparam logic [15:0] B_II  = 16'h0400;
    localparam logic [15:0] B_AI  = 16'h0200;
    localparam logic [15:0] B_AO  = 16'h0100;
    localparam logic [15:0] B_EO  = 16'h0080;
    localparam logic [15:0] B_SU  = 16'h0040;
    localparam logic [15:0] B_BI  = 16'h0020;
    localparam logic [15:0] B_OI  = 16'h0010;
    localparam logic [15:0] B_CE  = 16'h0008;
    localparam logic [15:0] B_CO  = 16'h0004;
    localparam logic [15:0] B_J   = 16'h0002;
    localparam logic [15:0] B_FI  = 16'h0001;

    localparam logic [15:0] IDLE_WORD = 16'h7FB7;
    localparam logic [15:0] HALT_WORD = IDLE_WORD | B_HLT;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [STEP_W-1:0] S0 = STEP_W'(0);
    localparam logic [STEP_W-1:0] S1 = STEP_W'(1);
    localparam logic [STEP_W-1:0] S2 = STEP_W'(2);
    localparam logic [STEP_W-1:0] S3 = STEP_W'(3);
    localparam logic [STEP_W-1:0] S4 = STEP_W'(4);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [STEP_W-1:0] r_step;
    logic [0:0]        r_state;
    logic [15:0]       w_act;
    logic [STEP_W-1:0] w_last;
    logic [STEP_W-1:0] w_next_step;
    logic              w_hlt_exec;

    // w_act marks the signals driven active; XOR with IDLE flips each to its active level
    always_comb begin
        w_act = 16'h0000;
        case (r_step)
            S0: w_act = B_CO | B_MI;
            S1: w_act = B_RO | B_II | B_CE;
            S2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: w_act = B_IO | B_MI;
                    OP_LDI: w_act = B_IO | B_AI;
                    OP_JMP: w_act = B_IO | B_J;
                    OP_JC:  w_act = flag_c ? (B_IO | B_J) : 16'h0000;
                    OP_JZ:  w_act = flag_z ? (B_IO | B_J) : 16'h0000;
                    OP_OUT: w_act = B_AO | B_OI;
                    OP_HLT: w_act = B_HLT;
                    default: w_act = 16'h0000;
                endcase
            end
            S3: begin
                case (opcode)
                    OP_LDA:         w_act = B_RO | B_AI;
                    OP_ADD, OP_SUB: w_act = B_RO | B_BI;
                    OP_STA:         w_act = B_AO | B_RI;
                    default:        w_act = 16'h0000;
                endcase
            end
            S4: begin
                case (opcode)
                    OP_ADD:  w_act = B_EO | B_AI | B_FI;
                    OP_SUB:  w_act = B_EO | B_AI | B_FI | B_SU;
                    default: w_act = 16'h0000;
                endcase
            end
            default: w_act = 16'h0000;
        endcase
    end

    always_comb begin
        w_last = S2;
        case (opcode)
            OP_LDA, OP_STA: w_last = S3;
            OP_ADD, OP_SUB: w_last = S4;
            default:        w_last = S2;
        endcase
    end

    // Steps above 4 are unreachable; fold them back to 0 if ever entered
    always_comb begin
        w_next_step = r_step + S1;
        if ((r_step == w_last) || (r_step > S4)) begin
            w_next_step = S0;
        end
    end

    assign w_hlt_exec = (r_step == S2) && (opcode == OP_HLT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step  <= S0;
            r_state <= ST_RUN;
        end else if ((r_state == ST_RUN) && run) begin
            if (w_hlt_exec) begin
                r_state <= ST_HALT;
                r_step  <= S0;
            end else begin
                r_step <= w_next_step;
            end
        end
    end

    always_comb begin
        if (r_state == ST_HALT) begin
            ctrl_word = HALT_WORD;
        end else if (run) begin
            ctrl_word = IDLE_WORD ^ w_act;
        end else begin
            ctrl_word = IDLE_WORD;
        end
    end

    assign step   = r_step;
    assign halted = (r_state == ST_HALT);

endmodule
